// File: rtl/or16_pkg.sv
// rtl/or16_pkg.sv - shared width, word type and reset constant for the or16 gate
package or16_pkg;
  localparam int OR16_WIDTH = 16;
  typedef logic [OR16_WIDTH-1:0] or16_word_t;
  localparam or16_word_t OR16_ZERO = '0;
endpackage

// File: rtl/or1_nand.sv
// rtl/or1_nand.sv - 1-bit OR cell built purely from two-input NAND gates
module or1_nand (
  input  logic x,
  input  logic y,
  output logic z
);
  logic nx;
  logic ny;

  // A 1 on either input pins that NAND's output low, so z resolves to 1 even if the other input is X.
  assign nx = ~(x & x);
  assign ny = ~(y & y);
  assign z  = ~(nx & ny);
endmodule

// File: rtl/or16.sv
// rtl/or16.sv - bit-sliced WIDTH-bit OR with nonzero flag and capture stage
// Build option: OR16_REG_OUT_EN makes out_q/out_nz_q flops, otherwise they bypass out/out_nz.
module or16
  import or16_pkg::*;
#(
  parameter int WIDTH = OR16_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             out_nz,
  output logic [WIDTH-1:0] out_q,
  output logic             out_nz_q
);
  localparam int LEAVES = 1 << $clog2(WIDTH);

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_slice
      or1_nand u_or (.x(a[i]), .y(b[i]), .z(out[i]));
    end
  endgenerate

  // Heap-indexed reduce tree: node[1] is the root, leaves sit at LEAVES..2*LEAVES-1, padded with 0.
  logic [2*LEAVES-1:1] node;

  generate
    for (i = 0; i < LEAVES; i++) begin : g_leaf
      if (i < WIDTH) begin : g_used
        assign node[LEAVES+i] = out[i];
      end else begin : g_pad
        assign node[LEAVES+i] = 1'b0;
      end
    end
    for (i = 1; i < LEAVES; i++) begin : g_tree
      or1_nand u_or (.x(node[2*i]), .y(node[2*i+1]), .z(node[i]));
    end
  endgenerate

  assign out_nz = node[1];

`ifdef OR16_REG_OUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= WIDTH'(OR16_ZERO);
      out_nz_q <= 1'b0;
    end else begin
      out_q    <= out;
      out_nz_q <= out_nz;
    end
  end
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, rst};
  assign out_q    = out;
  assign out_nz_q = out_nz;
`endif
endmodule

// File: tb/tb_or16.sv
// tb/tb_or16.sv - directed self-checking bench for or16 (both OR16_REG_OUT_EN builds)
module tb_or16;
  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] out;
  logic        out_nz;
  logic [15:0] out_q;
  logic        out_nz_q;
  int          checks;
  int          errors;

  or16 #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b),
    .out(out), .out_nz(out_nz), .out_q(out_q), .out_nz_q(out_nz_q)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    #5 clk = 1'b1;
    #5 clk = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clk = 1'b0;
    rst = 1'b1;
    a = 16'h0000;
    b = 16'h0000;
    #1;
    check("zero_out", out, 16'h0000);
    check("zero_nz", {15'd0, out_nz}, 16'h0000);

    a = 16'h0000; b = 16'hFFFF; #1;
    check("0_ffff_out", out, 16'hFFFF);
    check("0_ffff_nz", {15'd0, out_nz}, 16'h0001);

    a = 16'hFFFF; b = 16'hFFFF; #1;
    check("ffff_ffff_out", out, 16'hFFFF);
    check("ffff_ffff_nz", {15'd0, out_nz}, 16'h0001);

    a = 16'hAAAA; b = 16'h5555; #1;
    check("interleave_out", out, 16'hFFFF);

    a = 16'h3CC3; b = 16'h0FF0; #1;
    check("3cc3_out", out, 16'h3FF3);
`ifndef OR16_REG_OUT_EN
    check("bypass_out_q", out_q, 16'h3FF3);
    check("bypass_nz_q", {15'd0, out_nz_q}, 16'h0001);
`endif

    a = 16'h1234; b = 16'h9876; #1;
    check("1234_out", out, 16'h9A76);

    a = 16'h8000; b = 16'h0000; #1;
    check("msb_out", out, 16'h8000);
    check("msb_nz", {15'd0, out_nz}, 16'h0001);

    a = 16'h0000; b = 16'h0001; #1;
    check("lsb_nz", {15'd0, out_nz}, 16'h0001);

    a = 16'b0000_0000_0000_000x; b = 16'h0000; #1;
    check("x_prop_out", out, 16'b0000_0000_0000_000x);
    check("x_prop_nz", {15'd0, out_nz}, {15'd0, 1'bx});
    b = 16'h0001; #1;
    check("x_forced_out", out, 16'h0001);
    check("x_forced_nz", {15'd0, out_nz}, 16'h0001);

`ifdef OR16_REG_OUT_EN
    a = 16'h1234; b = 16'h9876; #1;
    check("rst_hold_q", out_q, 16'h0000);
    check("rst_hold_nz_q", {15'd0, out_nz_q}, 16'h0000);
    tick(); #1;
    check("rst_edge_q", out_q, 16'h0000);
    rst = 1'b0; #1;
    check("pre_edge_q", out_q, 16'h0000);
    tick(); #1;
    check("load_q", out_q, 16'h9A76);
    check("load_nz_q", {15'd0, out_nz_q}, 16'h0001);
    rst = 1'b1; #1;
    check("async_rst_q", out_q, 16'h0000);
    check("async_rst_nz_q", {15'd0, out_nz_q}, 16'h0000);
    check("rst_no_force_out", out, 16'h9A76);
    rst = 1'b0;
    a = 16'h3CC3; b = 16'h0FF0;
    tick(); #1;
    check("reload_q", out_q, 16'h3FF3);
    a = 16'h0000; b = 16'h0000;
    tick(); #1;
    check("zero_q", out_q, 16'h0000);
    check("zero_nz_q", {15'd0, out_nz_q}, 16'h0000);
`else
    a = 16'h1234; b = 16'h9876;
    tick(); #1;
    check("bypass_clocked_q", out_q, 16'h9A76);
    rst = 1'b0;
    a = 16'h0000; b = 16'h0000; #1;
    check("bypass_zero_q", out_q, 16'h0000);
    check("bypass_zero_nz_q", {15'd0, out_nz_q}, 16'h0000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
